mips_mem_access_unit: RTL

Initiator side of the data-memory interface. It accepts load/store requests from the MIPS datapath and drives the word-wide data memory through mem_address, write_data, sig_mem_read and sig_mem_write, then captures read_data. It supports word, halfword and byte accesses; sub-word stores use read-modify-write because the memory has no byte enables. It sits between the EX/MEM stage and mips_data_mem.

---
 rtl/mips_mem_pkg.sv | 45 ++++
 rtl/mips_byte_lane.sv | 52 +++++
 rtl/mips_mem_access_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings and decode helpers for the MIPS data-memory access unit.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic size_e access_size(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW:         return SZ_WORD;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_BYTE;
    endcase
  endfunction

  function automatic logic is_signed_load(input logic [2:0] op);
    return (op == OP_LH) || (op == OP_LB);
  endfunction

endpackage

// File: rtl/mips_byte_lane.sv
// Combinational lane steering: extracts a sub-word load result from a memory
// word and merges store data into a word, both keyed by offset and size.
module mips_byte_lane
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] word,
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  // Bit position of the addressed lane; big-endian puts offset 0 at the top.
  always_comb begin
    sh = 5'd0;
    case (size)
      SZ_BYTE: sh = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
      SZ_HALF: sh = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
      default: sh = 5'd0;
    endcase
  end

  always_comb begin
    shifted = word >> sh;
    mask    = 32'hFFFF_FFFF;
    rdata   = shifted;
    case (size)
      SZ_BYTE: begin
        mask  = 32'h0000_00FF << sh;
        rdata = sgn ? 32'($signed(shifted[7:0])) : {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        mask  = 32'h0000_FFFF << sh;
        rdata = sgn ? 32'($signed(shifted[15:0])) : {16'h0, shifted[15:0]};
      end
      default: begin
        mask  = 32'hFFFF_FFFF;
        rdata = shifted;
      end
    endcase
    merged = (word & ~mask) | ((data << sh) & mask);
  end

endmodule

// File: rtl/mips_mem_access_unit.sv
// Load/store initiator for the word-wide data memory; sub-word stores are
// performed as read-modify-write since the memory has no byte enables.
module mips_mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS  = 256,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  input  logic [31:0] read_data,
  output logic [31:0] mem_address,
  output logic [31:0] write_data,
  output logic        sig_mem_read,
  output logic        sig_mem_write
);

  state_e      state;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] word_idx;

  assign word_idx = {2'b00, req_addr[31:2]};

  always_comb begin
    misaligned = 1'b0;
    case (access_size(req_op))
      SZ_WORD: misaligned = |req_addr[1:0];
      SZ_HALF: misaligned = req_addr[0];
      default: misaligned = 1'b0;
    endcase
    out_of_range = word_idx >= 32'(MEM_WORDS);
  end

  mips_byte_lane #(.BIG_ENDIAN(BIG_ENDIAN)) u_lane (
    .word   (read_data),
    .data   (wdata_q),
    .offset (off_q),
    .size   (access_size(op_q)),
    .sgn    (is_signed_load(op_q)),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0;
      resp_err      <= 1'b0;
      mem_address   <= 32'h0;
      write_data    <= 32'h0;
      sig_mem_read  <= 1'b0;
      sig_mem_write <= 1'b0;
    end else begin
      resp_valid    <= 1'b0;
      sig_mem_read  <= 1'b0;
      sig_mem_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op;
            off_q     <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            // Errors skip the memory entirely so no strobe is ever raised.
            if (misaligned || out_of_range) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_op == OP_SW) begin
              state         <= S_WR;
              mem_address   <= word_idx;
              write_data    <= req_wdata;
              sig_mem_write <= 1'b1;
            end else begin
              state        <= is_store(req_op) ? S_RMW_RD : S_RD;
              mem_address  <= word_idx;
              sig_mem_read <= 1'b1;
            end
          end
        end
        S_RD: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= lane_rdata;
        end
        S_RMW_RD: begin
          state         <= S_WR;
          write_data    <= lane_merged;
          sig_mem_write <= 1'b1;
        end
        S_WR: begin
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        S_RESP: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
